// File: rtl/mult_pkg.sv
// Shared types and constants for the multi-cycle multiply sequencer.
package mult_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, MUL, FIX, DONE} mult_state_t;

    localparam int MULT_ITER_MAX = 31;
    localparam int MULT_W        = 32;

endpackage

// File: rtl/mult_sequencer_if.sv
// Pipeline-controller <-> multiply sequencer handshake and operand bus.
interface mult_sequencer_if;
    import mult_pkg::*;

    logic                  start;
    logic                  flush;
    logic [MULT_W-1:0]     op_a;
    logic [MULT_W-1:0]     op_b;
    logic [2*MULT_W-1:0]   acc_in;
    logic                  accumulate;
    logic                  signed_op;
    logic                  long_op;
    logic                  busy;
    logic                  done;
    logic [2*MULT_W-1:0]   result;
    logic                  n_flag;
    logic                  z_flag;

    modport master (
        output start, flush, op_a, op_b, acc_in, accumulate, signed_op, long_op,
        input  busy, done, result, n_flag, z_flag
    );

    modport slave (
        input  start, flush, op_a, op_b, acc_in, accumulate, signed_op, long_op,
        output busy, done, result, n_flag, z_flag
    );

endinterface

// File: rtl/mult_counter.sv
// Generic up-counter with synchronous clear and enable.
module mult_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)     r_q <= '0;
        else if (i_clr) r_q <= '0;
        else if (i_en)  r_q <= r_q + 1'b1;
    end

    assign o_q = r_q;

endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiply datapath: operand latches, magnitude setup, one 64-bit
// add per iteration, and final sign fix-up plus accumulate.
module mult_datapath
    import mult_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  i_load,
    input  logic                  i_setup,
    input  logic                  i_iter,
    input  logic                  i_fix,
    input  logic [MULT_W-1:0]     i_op_a,
    input  logic [MULT_W-1:0]     i_op_b,
    input  logic [2*MULT_W-1:0]   i_acc,
    input  logic                  i_accumulate,
    input  logic                  i_signed,
    input  logic                  i_long,
    output logic                  o_mplier_hi_zero,
    output logic [2*MULT_W-1:0]   o_result,
    output logic                  o_n,
    output logic                  o_z
);

    logic [MULT_W-1:0]   r_op_a, r_op_b, r_mplier;
    logic [2*MULT_W-1:0] r_acc, r_mcand, r_product, r_result;
    logic                r_acc_en, r_signed, r_long, r_neg, r_n, r_z;

    logic [MULT_W-1:0]   w_mag_a, w_mag_b, w_short_lo;
    logic [2*MULT_W-1:0] w_sum, w_signed_p, w_long_p, w_fix;

    // |x| of 0x80000000 wraps back to 0x80000000, which is the correct unsigned magnitude
    assign w_mag_a    = (r_signed && r_op_a[MULT_W-1]) ? -r_op_a : r_op_a;
    assign w_mag_b    = (r_signed && r_op_b[MULT_W-1]) ? -r_op_b : r_op_b;
    assign w_sum      = r_product + (r_mplier[0] ? r_mcand : '0);
    assign w_signed_p = r_neg ? -r_product : r_product;
    assign w_long_p   = w_signed_p + (r_acc_en ? r_acc : '0);
    assign w_short_lo = w_signed_p[MULT_W-1:0] + (r_acc_en ? r_acc[MULT_W-1:0] : '0);
    assign w_fix      = r_long ? w_long_p : {{MULT_W{1'b0}}, w_short_lo};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_acc     <= '0;
            r_acc_en  <= 1'b0;
            r_signed  <= 1'b0;
            r_long    <= 1'b0;
            r_neg     <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
            r_result  <= '0;
            r_n       <= 1'b0;
            r_z       <= 1'b0;
        end else begin
            if (i_load) begin
                r_op_a   <= i_op_a;
                r_op_b   <= i_op_b;
                r_acc    <= i_acc;
                r_acc_en <= i_accumulate;
                r_signed <= i_signed;
                r_long   <= i_long;
            end
            if (i_setup) begin
                r_mcand   <= {{MULT_W{1'b0}}, w_mag_a};
                r_mplier  <= w_mag_b;
                r_product <= '0;
                r_neg     <= r_signed & (r_op_a[MULT_W-1] ^ r_op_b[MULT_W-1]);
            end
            if (i_iter) begin
                r_product <= w_sum;
                r_mcand   <= r_mcand << 1;
                r_mplier  <= r_mplier >> 1;
            end
            if (i_fix) begin
                r_result <= w_fix;
                r_n      <= r_long ? w_fix[2*MULT_W-1] : w_fix[MULT_W-1];
                r_z      <= (w_fix == '0);
            end
        end
    end

    assign o_mplier_hi_zero = (r_mplier[MULT_W-1:1] == '0);
    assign o_result         = r_result;
    assign o_n              = r_n;
    assign o_z              = r_z;

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle multiply controller: FSM driving the shift-add datapath.
//   state | meaning
//   IDLE  | waiting for start
//   SETUP | form operand magnitudes and result sign, clear product/count
//   MUL   | one shift-add iteration per cycle
//   FIX   | apply sign, add accumulate, register result and flags
//   DONE  | done pulse; a new start is accepted here
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int EARLY_TERM = 1
) (
    input  logic           clk,
    input  logic           rst_b,
    mult_sequencer_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_SETUP = SETUP;
    localparam logic [2:0] ST_MUL   = MUL;
    localparam logic [2:0] ST_FIX   = FIX;
    localparam logic [2:0] ST_DONE  = DONE;

    logic [2:0] r_state, w_next;
    logic [4:0] w_count;
    logic       w_load, w_setup, w_iter, w_fix;
    logic       w_mplier_hi_zero, w_last;

    assign w_last = (w_count == 5'(MULT_ITER_MAX)) || ((EARLY_TERM != 0) && w_mplier_hi_zero);

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_setup = 1'b0;
        w_iter  = 1'b0;
        w_fix   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_next = ST_SETUP;
                    w_load = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_setup = 1'b1;
                w_next  = ST_MUL;
            end
            ST_MUL: begin
                w_iter = 1'b1;
                if (w_last) w_next = ST_FIX;
            end
            ST_FIX: begin
                w_fix  = 1'b1;
                w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
        // Flush kills every strobe so a flushed FIX leaves the old result intact
        if (bus.flush) begin
            w_next  = ST_IDLE;
            w_load  = 1'b0;
            w_setup = 1'b0;
            w_iter  = 1'b0;
            w_fix   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    mult_counter #(.W(5)) u_count (
        .clk   (clk),
        .rst_b (rst_b),
        .i_clr (w_setup),
        .i_en  (w_iter),
        .o_q   (w_count)
    );

    mult_datapath u_dp (
        .clk              (clk),
        .rst_b            (rst_b),
        .i_load           (w_load),
        .i_setup          (w_setup),
        .i_iter           (w_iter),
        .i_fix            (w_fix),
        .i_op_a           (bus.op_a),
        .i_op_b           (bus.op_b),
        .i_acc            (bus.acc_in),
        .i_accumulate     (bus.accumulate),
        .i_signed         (bus.signed_op),
        .i_long           (bus.long_op),
        .o_mplier_hi_zero (w_mplier_hi_zero),
        .o_result         (bus.result),
        .o_n              (bus.n_flag),
        .o_z              (bus.z_flag)
    );

    assign bus.busy = (r_state == ST_SETUP) || (r_state == ST_MUL) || (r_state == ST_FIX);
    assign bus.done = (r_state == ST_DONE);

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer (EARLY_TERM=1 main DUT, EARLY_TERM=0 shadow DUT).
module tb_mult_sequencer;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mult_sequencer_if bus1 ();
    mult_sequencer_if bus0 ();

    assign bus0.start      = bus1.start;
    assign bus0.flush      = bus1.flush;
    assign bus0.op_a       = bus1.op_a;
    assign bus0.op_b       = bus1.op_b;
    assign bus0.acc_in     = bus1.acc_in;
    assign bus0.accumulate = bus1.accumulate;
    assign bus0.signed_op  = bus1.signed_op;
    assign bus0.long_op    = bus1.long_op;

    mult_sequencer #(.EARLY_TERM(1)) dut1 (.clk(clk), .rst_b(rst_b), .bus(bus1));
    mult_sequencer #(.EARLY_TERM(0)) dut0 (.clk(clk), .rst_b(rst_b), .bus(bus0));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [63:0] acc,
                         input logic acce, input logic sgn, input logic lng);
        bus1.op_a       = a;
        bus1.op_b       = b;
        bus1.acc_in     = acc;
        bus1.accumulate = acce;
        bus1.signed_op  = sgn;
        bus1.long_op    = lng;
    endtask

    task automatic wait_idle0();
        int k = 0;
        while (bus0.busy && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Launches one op, measures latency (edges after the accepting edge) and busy cycles.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] acc, input logic acce, input logic sgn, input logic lng,
                         input int exp_lat, input logic [63:0] exp_res, input logic exp_n,
                         input logic exp_z, input bit chk0);
        int n = 0, lat1 = -1, lat0 = -1, busy_cnt = 0;
        logic [63:0] res1 = '0, res0 = '0;
        logic n1 = 1'b0, z1 = 1'b0;
        wait_idle0();
        @(negedge clk);
        drive(a, b, acc, acce, sgn, lng);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        while ((lat1 < 0 || (chk0 && lat0 < 0)) && n < 80) begin
            if (bus1.busy && lat1 < 0) busy_cnt++;
            if (bus1.done && lat1 < 0) begin
                lat1 = n; res1 = bus1.result; n1 = bus1.n_flag; z1 = bus1.z_flag;
            end
            if (bus0.done && lat0 < 0) begin
                lat0 = n; res0 = bus0.result;
            end
            if (lat1 < 0 || (chk0 && lat0 < 0)) begin
                @(negedge clk);
                n++;
            end
        end
        chk({tag, " latency"}, 64'(lat1), 64'(exp_lat));
        chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        chk({tag, " result"}, res1, exp_res);
        chk({tag, " n_flag"}, 64'(n1), 64'(exp_n));
        chk({tag, " z_flag"}, 64'(z1), 64'(exp_z));
        if (chk0) begin
            chk({tag, " et0 latency"}, 64'(lat0), 64'd34);
            chk({tag, " et0 result"}, res0, exp_res);
        end
    endtask

    initial begin
        int n;
        bit seen;
        bus1.start = 1'b0;
        bus1.flush = 1'b0;
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(bus1.busy), 64'd0);
        chk("reset done", 64'(bus1.done), 64'd0);
        chk("reset result", bus1.result, 64'd0);
        chk("reset n", 64'(bus1.n_flag), 64'd0);
        chk("reset z", 64'(bus1.z_flag), 64'd0);
        rst_b = 1'b1;
        @(negedge clk);

        do_op("u_short_7x6", 32'd7, 32'd6, 64'd0, 1'b0, 1'b0, 1'b0,
              5, 64'h2A, 1'b0, 1'b0, 1'b0);
        do_op("u_long_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 1'b0, 1'b0, 1'b1,
              34, 64'hFFFFFFFE_00000001, 1'b1, 1'b0, 1'b1);
        do_op("s_long_m1x2", 32'hFFFFFFFF, 32'd2, 64'd0, 1'b0, 1'b1, 1'b1,
              4, 64'hFFFFFFFF_FFFFFFFE, 1'b1, 1'b0, 1'b0);
        do_op("s_long_minmin", 32'h80000000, 32'h80000000, 64'd0, 1'b0, 1'b1, 1'b1,
              34, 64'h40000000_00000000, 1'b0, 1'b0, 1'b1);
        do_op("acc_long_wrap", 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0, 1'b1,
              3, 64'd0, 1'b0, 1'b1, 1'b0);
        do_op("acc_short_wrap", 32'h80000000, 32'd2, 64'd5, 1'b1, 1'b0, 1'b0,
              4, 64'd5, 1'b0, 1'b0, 1'b0);
        do_op("s_short_m3x5", 32'hFFFFFFFD, 32'd5, 64'd0, 1'b0, 1'b1, 1'b0,
              5, 64'h00000000_FFFFFFF1, 1'b1, 1'b0, 1'b0);
        do_op("zero_mplier", 32'h55, 32'd0, 64'h1234, 1'b1, 1'b0, 1'b0,
              3, 64'h1234, 1'b0, 1'b0, 1'b0);

        // start during MUL is ignored: 5 x 0x100 runs 9 iterations
        wait_idle0();
        @(negedge clk);
        drive(32'd5, 32'h100, 64'd0, 1'b0, 1'b0, 1'b1);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        n = 0;
        repeat (3) begin @(negedge clk); n++; end
        drive(32'd9, 32'd9, 64'd0, 1'b0, 1'b0, 1'b1);
        bus1.start = 1'b1;
        @(negedge clk); n++;
        bus1.start = 1'b0;
        while (!bus1.done && n < 80) begin @(negedge clk); n++; end
        chk("ignore_start latency", 64'(n), 64'd11);
        chk("ignore_start result", bus1.result, 64'h500);
        @(negedge clk);
        chk("ignore_start no requeue", 64'(bus1.busy), 64'd0);

        // flush mid-MUL: back to IDLE, no done, old result kept
        wait_idle0();
        @(negedge clk);
        drive(32'd2, 32'h100, 64'd0, 1'b0, 1'b0, 1'b1);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (3) @(negedge clk);
        bus1.flush = 1'b1;
        @(negedge clk);
        bus1.flush = 1'b0;
        chk("flush busy", 64'(bus1.busy), 64'd0);
        chk("flush et0 busy", 64'(bus0.busy), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus1.done) seen = 1'b1;
        end
        chk("flush no_done", 64'(seen), 64'd0);
        chk("flush result kept", bus1.result, 64'h500);

        // flush and start together in IDLE: start dropped
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.flush = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        bus1.flush = 1'b0;
        chk("flush_start busy", 64'(bus1.busy), 64'd0);

        // back-to-back: start held in the DONE cycle is accepted
        do_op("b2b_first", 32'd7, 32'd6, 64'd0, 1'b0, 1'b0, 1'b0,
              5, 64'h2A, 1'b0, 1'b0, 1'b0);
        drive(32'd3, 32'd3, 64'd0, 1'b0, 1'b0, 1'b0);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        n = 0;
        while (!bus1.done && n < 80) begin @(negedge clk); n++; end
        chk("b2b latency", 64'(n), 64'd4);
        chk("b2b result", bus1.result, 64'd9);

        // async reset mid-MUL
        @(negedge clk);
        drive(32'd3, 32'h100, 64'd0, 1'b0, 1'b0, 1'b1);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("rst busy", 64'(bus1.busy), 64'd0);
        chk("rst result", bus1.result, 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst stays idle", 64'(bus1.busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
